// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_rx
// Purpose  : SPI peripheral-side receiver. Synchronizes sclk/cs/mosi into clk,
//            deserializes LSB-first frames of DATA_W bits and strobes done.
//            Optional macro SPI_SLAVE_RX_FRAME_ERR_EN adds a frame_err output.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2,
    parameter int LEAD_EDGES  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);

    localparam int c_BIT_W  = $clog2(DATA_W + 1);
    localparam int c_LEAD_W = (LEAD_EDGES > 0) ? $clog2(LEAD_EDGES + 1) : 1;

    localparam logic [c_BIT_W-1:0]  c_BIT_LAST = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0]  c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [c_LEAD_W-1:0] c_LEAD_MAX = c_LEAD_W'(LEAD_EDGES);
    localparam logic [c_LEAD_W-1:0] c_LEAD_ONE = c_LEAD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                  r_state;
    logic [SYNC_STAGES-1:0]  r_sclk_sync;
    logic [SYNC_STAGES-1:0]  r_cs_sync;
    logic [SYNC_STAGES-1:0]  r_mosi_sync;
    logic                    r_sclk_prev;
    logic [DATA_W-1:0]       r_shift;
    logic [c_BIT_W-1:0]      r_bit_cnt;
    logic [c_LEAD_W-1:0]     r_lead_cnt;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic                    r_ovf_seen;
`endif

    logic w_sclk_s;
    logic w_cs_s;
    logic w_mosi_s;
    logic w_fall;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
    assign w_fall   = r_sclk_prev & ~w_sclk_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_prev <= w_sclk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_lead_cnt <= '0;
            dout       <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
            r_ovf_seen <= 1'b0;
            frame_err  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
            frame_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (!w_cs_s) begin
                        r_shift    <= '0;
                        r_bit_cnt  <= '0;
                        r_lead_cnt <= '0;
                        busy       <= 1'b1;
                        r_state    <= S_RECV;
                    end
                end
                S_RECV: begin
                    // cs rising wins over a coincident sclk fall
                    if (w_cs_s) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                        frame_err <= 1'b1;
`endif
                    end else if (w_fall) begin
                        if (r_lead_cnt < c_LEAD_MAX) begin
                            r_lead_cnt <= r_lead_cnt + c_LEAD_ONE;
                        end else begin
                            r_shift[r_bit_cnt] <= w_mosi_s;
                            r_bit_cnt          <= r_bit_cnt + c_BIT_ONE;
                            if (r_bit_cnt == c_BIT_LAST) begin
                                // final bit bypasses the shift register so dout lands with done
                                dout    <= {w_mosi_s, r_shift[DATA_W-2:0]};
                                done    <= 1'b1;
                                r_state <= S_HOLD;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                                r_ovf_seen <= 1'b0;
`endif
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (w_cs_s) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
                    else if (w_fall && !r_ovf_seen) begin
                        r_ovf_seen <= 1'b1;
                        frame_err  <= 1'b1;
                    end
`endif
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_rx
// Purpose  : Directed self-checking bench for spi_slave_rx.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int c_H = 8;  // sclk half period in clk cycles

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic [11:0] dout;
    logic        done;
    logic        busy;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    logic        frame_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int dbl_cnt  = 0;
    int err_cnt  = 0;
    logic [11:0] last_val = '0;
    time done_t = 0;
    time err_t  = 0;
    logic prev_done = 1'b0;

    spi_slave_rx dut (
        .clk  (clk),
        .rst  (rst),
        .sclk (sclk),
        .cs   (cs),
        .mosi (mosi),
        .dout (dout),
        .done (done),
        .busy (busy)
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        ,
        .frame_err (frame_err)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            last_val = dout;
            done_t   = $time;
            if (prev_done) dbl_cnt++;
        end
        prev_done = done;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        if (frame_err) begin
            err_cnt++;
            err_t = $time;
        end
`endif
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        cs = 1'b0;
        wait_clk(c_H);
        sclk = 1'b1;
        wait_clk(c_H);
        sclk = 1'b0;
        wait_clk(c_H);
    endtask

    task automatic send_bits(input logic [11:0] data, input int n);
        for (int i = 0; i < n; i++) begin
            mosi = data[i];
            sclk = 1'b1;
            wait_clk(c_H);
            sclk = 1'b0;
            wait_clk(c_H);
        end
    endtask

    task automatic frame_end();
        wait_clk(c_H);
        cs = 1'b1;
        wait_clk(2 * c_H);
    endtask

    task automatic send_frame(input logic [11:0] data);
        frame_start();
        send_bits(data, 12);
        frame_end();
    endtask

    initial begin
        int d0;
        int e0;
        logic [11:0] w;

        wait_clk(3);
        check_eq("reset_dout", 32'(dout), 32'h0);
        check_eq("reset_done", 32'(done), 32'h0);
        check_eq("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        wait_clk(4);

        // single frame 0xA5C
        d0 = done_cnt;
        w  = 12'hA5C;
        frame_start();
        send_bits(w, 4);
        check_eq("a5c_busy_mid", 32'(busy), 32'h1);
        w = 12'h0A5;
        send_bits(w, 8);
        frame_end();
        check_eq("a5c_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("a5c_dout", 32'(last_val), 32'hA5C);
        check_eq("a5c_dout_held", 32'(dout), 32'hA5C);
        check_eq("a5c_busy_end", 32'(busy), 32'h0);

        // back-to-back frames
        d0 = done_cnt;
        send_frame(12'h001);
        check_eq("b2b_first_dout", 32'(last_val), 32'h001);
        send_frame(12'hFFF);
        check_eq("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check_eq("b2b_second_dout", 32'(last_val), 32'hFFF);

        // good frame then aborted frame
        send_frame(12'h123);
        d0 = done_cnt;
        e0 = err_cnt;
        frame_start();
        send_bits(12'h3C3, 5);
        frame_end();
        check_eq("abort_done_cnt", 32'(done_cnt - d0), 32'd0);
        check_eq("abort_dout", 32'(dout), 32'h123);
        check_eq("abort_busy", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check_eq("abort_frame_err", 32'(err_cnt - e0), 32'd1);
`endif

        // reset mid-frame
        d0 = done_cnt;
        e0 = err_cnt;
        frame_start();
        send_bits(12'h555, 6);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        cs  = 1'b1;
        check_eq("rst_mid_dout", 32'(dout), 32'h0);
        check_eq("rst_mid_done", 32'(done), 32'h0);
        check_eq("rst_mid_busy", 32'(busy), 32'h0);
        wait_clk(4 * c_H);
        check_eq("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
        send_frame(12'h3C3);
        check_eq("rst_after_dout", 32'(dout), 32'h3C3);
        check_eq("rst_after_done_cnt", 32'(done_cnt - d0), 32'd1);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check_eq("rst_no_frame_err", 32'(err_cnt - e0), 32'd0);
`endif

        // sclk noise with cs high
        d0 = done_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            mosi = ~mosi;
            sclk = 1'b1;
            wait_clk(c_H);
            sclk = 1'b0;
            wait_clk(c_H);
            check_eq("noise_busy", 32'(busy), 32'h0);
        end
        check_eq("noise_done_cnt", 32'(done_cnt - d0), 32'd0);
        check_eq("noise_dout", 32'(dout), 32'h3C3);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check_eq("noise_frame_err", 32'(err_cnt - e0), 32'd0);
`endif

        // overlength frame
        d0 = done_cnt;
        e0 = err_cnt;
        frame_start();
        send_bits(12'h800, 12);
        send_bits(12'hFFF, 2);
        frame_end();
        check_eq("ovl_done_cnt", 32'(done_cnt - d0), 32'd1);
        check_eq("ovl_dout", 32'(dout), 32'h800);
        check_eq("ovl_busy", 32'(busy), 32'h0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
        check_eq("ovl_frame_err", 32'(err_cnt - e0), 32'd1);
        check_eq("ovl_err_after_done", 32'(err_t > done_t), 32'h1);
`endif

        check_eq("done_single_cycle", 32'(dbl_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
